// File: rtl/cpu_pkg.sv
// Shared opcode constants and FSM state encoding for the multi-cycle CPU.
package cpu_pkg;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_LDI  = 4'd5;
   localparam logic [3:0] OP_LD   = 4'd6;
   localparam logic [3:0] OP_ST   = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_JMP  = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALTED = 3'd5;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT with carry (ADD carry-out, SUB borrow).
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] y,
   output logic          c_out
);

   logic [DW:0] sum;

   // Result and carry selection by opcode
   always_comb begin
      y     = '0;
      c_out = 1'b0;
      sum   = {1'b0, a} + {1'b0, b};
      case (op)
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_ADD: begin
            y     = sum[DW-1:0];
            c_out = sum[DW];
         end
         OP_SUB: begin
            y     = a - b;
            c_out = (a < b);
         end
         OP_SLT: y = (a < b) ? DW'(1) : '0;
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALTED, 4 registers, inline dmem.
module mc_cpu_core
   import cpu_pkg::*;
#(
   parameter int DW      = 8,
   parameter int IMEM_AW = 4,
   parameter int DMEM_AW = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [15:0]        imem_data,
   output logic               halted,
   output logic               retire,
   output logic               carry,
   input  logic [1:0]         dbg_sel,
   output logic [DW-1:0]      dbg_data
);

   logic [2:0]         state;
   logic [IMEM_AW-1:0] pc;
   logic [15:0]        ir;
   logic [DW-1:0]      a, b, res;
   logic [DW-1:0]      regs [4];
   logic [DW-1:0]      dmem [2**DMEM_AW];

   logic [3:0]         op;
   logic [1:0]         rd, rs1, rs2;
   logic [DW-1:0]      imm_dw;
   logic [IMEM_AW-1:0] imm_pc, pc_inc;
   logic [DMEM_AW-1:0] d_addr;
   logic [DW-1:0]      alu_y;
   logic               alu_c;

   // Field decode and address/immediate sizing
   always_comb begin
      op     = ir[15:12];
      rd     = ir[11:10];
      rs1    = ir[9:8];
      rs2    = ir[7:6];
      imm_dw = DW'(ir[7:0]);
      imm_pc = IMEM_AW'(ir[7:0]);
      pc_inc = pc + IMEM_AW'(1);
      d_addr = DMEM_AW'(a);
   end

   assign imem_addr = pc;
   assign halted    = (state == S_HALTED);
   assign dbg_data  = regs[dbg_sel];

   cpu_alu #(.DW(DW)) u_alu (
      .op    (op),
      .a     (a),
      .b     (b),
      .y     (alu_y),
      .c_out (alu_c)
   );

   // Main FSM, PC, register file, flags and retire pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_FETCH;
         pc     <= '0;
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         res    <= '0;
         carry  <= 1'b0;
         retire <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (state)
            S_FETCH: begin
               if (run) begin
                  ir    <= imem_data;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (op == OP_BEQ) begin
                  a <= regs[rd];
                  b <= regs[rs1];
               end else begin
                  a <= regs[rs1];
                  b <= regs[rs2];
               end
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (op)
                  OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
                     res <= alu_y;
                     if (op == OP_ADD || op == OP_SUB) carry <= alu_c;
                     state <= S_WB;
                  end
                  OP_LDI: begin
                     res   <= imm_dw;
                     state <= S_WB;
                  end
                  OP_LD:   state <= S_MEM;
                  OP_BEQ: begin
                     pc     <= (a == b) ? imm_pc : pc_inc;
                     retire <= 1'b1;
                     state  <= S_FETCH;
                  end
                  OP_JMP: begin
                     pc     <= imm_pc;
                     retire <= 1'b1;
                     state  <= S_FETCH;
                  end
                  OP_HALT: state <= S_HALTED;
                  default: begin
                     // ST (dmem write is in its own block) and NOPs
                     pc     <= pc_inc;
                     retire <= 1'b1;
                     state  <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               res   <= dmem[d_addr];
               state <= S_WB;
            end
            S_WB: begin
               regs[rd] <= res;
               pc       <= pc_inc;
               retire   <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALTED: ;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Data memory write (not reset; suppressed while reset is asserted)
   always_ff @(posedge clk) begin
      if (!reset && state == S_EXEC && op == OP_ST) dmem[d_addr] <= b;
   end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed table-driven bench for mc_cpu_core (DW=8 and DW=4 instances).
module tb_mc_cpu_core;

   logic        clk = 1'b0;
   logic        reset, run, run4;
   logic [3:0]  imem_addr, imem_addr4;
   logic [15:0] imem_data, imem_data4;
   logic        halted, retire, carry, halted4, retire4, carry4;
   logic [1:0]  dbg_sel, dbg_sel4;
   logic [7:0]  dbg_data;
   logic [3:0]  dbg_data4;
   logic [15:0] prog [16];
   logic [15:0] prog4 [16];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign imem_data  = prog[imem_addr];
   assign imem_data4 = prog4[imem_addr4];

   mc_cpu_core #(.DW(8), .IMEM_AW(4), .DMEM_AW(4)) dut (
      .clk(clk), .reset(reset), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
      .halted(halted), .retire(retire), .carry(carry), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   mc_cpu_core #(.DW(4), .IMEM_AW(4), .DMEM_AW(4)) dut4 (
      .clk(clk), .reset(reset), .run(run4), .imem_addr(imem_addr4), .imem_data(imem_data4),
      .halted(halted4), .retire(retire4), .carry(carry4), .dbg_sel(dbg_sel4), .dbg_data(dbg_data4)
   );

   function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] d, s1, s2);
      return {op, d, s1, s2, 6'b0};
   endfunction
   function automatic logic [15:0] ri(input logic [3:0] op, input logic [1:0] d, s1,
                                      input logic [7:0] imm);
      return {op, d, s1, imm};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Place instr at current PC, accept it, count edges until retire (or halted).
   task automatic step(input logic [15:0] instr, output int lat);
      bit done = 0;
      lat = 0;
      prog[imem_addr] = instr;
      run = 1'b1;
      for (int i = 0; i < 10 && !done; i++) begin
         @(posedge clk); lat++;
         #1 run = 1'b0;
         @(negedge clk);
         if (retire || halted) done = 1;
      end
      if (!done) begin
         n_err++;
         $display("FAIL step timeout: got no retire expected retire within 10");
      end
   endtask

   task automatic step4(input logic [15:0] instr, output int lat);
      bit done = 0;
      lat = 0;
      prog4[imem_addr4] = instr;
      run4 = 1'b1;
      for (int i = 0; i < 10 && !done; i++) begin
         @(posedge clk); lat++;
         #1 run4 = 1'b0;
         @(negedge clk);
         if (retire4) done = 1;
      end
      if (!done) begin
         n_err++;
         $display("FAIL step4 timeout: got no retire expected retire within 10");
      end
   endtask

   task automatic rd_reg(input logic [1:0] s, output logic [7:0] v);
      dbg_sel = s;
      #1 v = dbg_data;
   endtask

   typedef struct {
      logic [15:0] instr;
      int          lat;
      logic [1:0]  reg_sel;
      logic [7:0]  reg_val;
      logic        c;
      logic [3:0]  pc;
   } vec_t;

   vec_t vt [20];

   initial begin
      int         lat;
      logic [7:0] v;
      logic [3:0] hold_pc;

      foreach (prog[i])  prog[i]  = 16'hA000;
      foreach (prog4[i]) prog4[i] = 16'hA000;

      vt[0]  = '{ri(4'd5, 2'd1, 2'd0, 8'd200), 4, 2'd1, 8'd200, 1'b0, 4'd1};
      vt[1]  = '{ri(4'd5, 2'd2, 2'd0, 8'd100), 4, 2'd2, 8'd100, 1'b0, 4'd2};
      vt[2]  = '{rr(4'd2, 2'd3, 2'd1, 2'd2),   4, 2'd3, 8'd44,  1'b1, 4'd3};
      vt[3]  = '{ri(4'd5, 2'd0, 2'd0, 8'd3),   4, 2'd0, 8'd3,   1'b1, 4'd4};
      vt[4]  = '{ri(4'd5, 2'd1, 2'd0, 8'd5),   4, 2'd1, 8'd5,   1'b1, 4'd5};
      vt[5]  = '{rr(4'd3, 2'd2, 2'd0, 2'd1),   4, 2'd2, 8'd254, 1'b1, 4'd6};
      vt[6]  = '{rr(4'd4, 2'd3, 2'd0, 2'd1),   4, 2'd3, 8'd1,   1'b1, 4'd7};
      vt[7]  = '{ri(4'd5, 2'd1, 2'd0, 8'd7),   4, 2'd1, 8'd7,   1'b1, 4'd8};
      vt[8]  = '{ri(4'd5, 2'd2, 2'd0, 8'h5A),  4, 2'd2, 8'h5A,  1'b1, 4'd9};
      vt[9]  = '{rr(4'd7, 2'd0, 2'd1, 2'd2),   3, 2'd2, 8'h5A,  1'b1, 4'd10};
      vt[10] = '{rr(4'd6, 2'd3, 2'd1, 2'd0),   5, 2'd3, 8'h5A,  1'b1, 4'd11};
      vt[11] = '{rr(4'd2, 2'd0, 2'd0, 2'd0),   4, 2'd0, 8'd6,   1'b0, 4'd12};
      vt[12] = '{ri(4'd8, 2'd3, 2'd2, 8'd14),  3, 2'd3, 8'h5A,  1'b0, 4'd14};
      vt[13] = '{ri(4'd8, 2'd0, 2'd1, 8'd2),   3, 2'd0, 8'd6,   1'b0, 4'd15};
      vt[14] = '{rr(4'd1, 2'd1, 2'd1, 2'd0),   4, 2'd1, 8'd7,   1'b0, 4'd0};
      vt[15] = '{ri(4'd9, 2'd0, 2'd0, 8'd15),  3, 2'd1, 8'd7,   1'b0, 4'd15};
      vt[16] = '{rr(4'd0, 2'd2, 2'd2, 2'd1),   4, 2'd2, 8'd2,   1'b0, 4'd0};
      vt[17] = '{16'hA000,                     3, 2'd2, 8'd2,   1'b0, 4'd1};
      vt[18] = '{rr(4'd3, 2'd0, 2'd0, 2'd1),   4, 2'd0, 8'd255, 1'b1, 4'd2};
      vt[19] = '{rr(4'd4, 2'd3, 2'd1, 2'd0),   4, 2'd3, 8'd1,   1'b1, 4'd3};

      reset = 1'b1; run = 1'b0; run4 = 1'b0; dbg_sel = 2'd0; dbg_sel4 = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // reset state
      chk("rst_pc", imem_addr, 0);
      chk("rst_halted", halted, 0);
      chk("rst_retire", retire, 0);
      chk("rst_carry", carry, 0);
      for (int r = 0; r < 4; r++) begin
         rd_reg(2'(r), v);
         chk($sformatf("rst_r%0d", r), v, 0);
      end

      // table-driven instruction vectors
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         step(vt[i].instr, lat);
         chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("v%0d_pc", i), imem_addr, vt[i].pc);
         chk($sformatf("v%0d_carry", i), carry, vt[i].c);
         rd_reg(vt[i].reg_sel, v);
         chk($sformatf("v%0d_reg", i), v, vt[i].reg_val);
      end

      // run=0 holds FETCH with PC stable
      hold_pc = imem_addr;
      repeat (5) begin
         @(negedge clk);
         chk("hold_pc", imem_addr, hold_pc);
         chk("hold_retire", retire, 0);
      end

      // reset during EXEC of ADD r1,r1,r1 (r1=7)
      prog[imem_addr] = rr(4'd2, 2'd1, 2'd1, 2'd1);
      run = 1'b1;
      @(posedge clk);            // accept
      #1 run = 1'b0;
      @(posedge clk);            // DECODE -> EXEC
      @(negedge clk) reset = 1'b1;
      @(posedge clk);            // edge in EXEC with reset
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rx_pc", imem_addr, 0);
      chk("rx_carry", carry, 0);
      chk("rx_retire", retire, 0);
      for (int r = 0; r < 4; r++) begin
         rd_reg(2'(r), v);
         chk($sformatf("rx_r%0d", r), v, 0);
      end

      // dmem survives reset: LDI r1,7; LD r2,[r1]
      @(negedge clk);
      step(ri(4'd5, 2'd1, 2'd0, 8'd7), lat);
      step(rr(4'd6, 2'd2, 2'd1, 2'd0), lat);
      chk("ld_after_rst_lat", lat, 5);
      rd_reg(2'd2, v);
      chk("ld_after_rst_val", v, 8'h5A);

      // HALT freezes everything
      @(negedge clk);
      step(16'hF000, lat);
      chk("halt_flag", halted, 1);
      hold_pc = imem_addr;
      foreach (prog[i]) prog[i] = ri(4'd5, 2'd1, 2'd0, 8'h33);
      run = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("halt_retire", retire, 0);
         chk("halt_pc", imem_addr, hold_pc);
      end
      run = 1'b0;
      rd_reg(2'd1, v);
      chk("halt_r1", v, 7);
      chk("halt_still", halted, 1);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      chk("halt_exit", halted, 0);
      chk("halt_exit_pc", imem_addr, 0);

      // DW=4 instance
      @(negedge clk);
      step4(ri(4'd5, 2'd1, 2'd0, 8'hAB), lat);
      dbg_sel4 = 2'd1;
      #1 chk("dw4_ldi", dbg_data4, 4'hB);
      step4(ri(4'd5, 2'd2, 2'd0, 8'h01), lat);
      step4(ri(4'd5, 2'd3, 2'd0, 8'h0F), lat);
      step4(rr(4'd2, 2'd0, 2'd3, 2'd2), lat);
      chk("dw4_add_lat", lat, 4);
      dbg_sel4 = 2'd0;
      #1 chk("dw4_add", dbg_data4, 0);
      chk("dw4_carry", carry4, 1);
      chk("dw4_pc", imem_addr4, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mc_cpu_core.md
MC_CPU_CORE -- requirements
Module: mc_cpu_core

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning datapath/register width in bits (legal 4..16).
REQ-002 The block SHALL have parameter IMEM_AW, default 4, meaning the program counter width (instruction space 2^IMEM_AW words).
REQ-003 The block SHALL have parameter DMEM_AW, default 4, meaning the internal data memory address width (2^DMEM_AW words of DW bits).
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port run, input, 1 bit: permits the fetch of the next instruction.
REQ-007 The block SHALL have port imem_addr, output, IMEM_AW bits: equals PC.
REQ-008 The block SHALL have port imem_data, input, 16 bits: instruction word, combinational from imem_addr.
REQ-009 The block SHALL have port halted, output, 1 bit: high in HALTED state.
REQ-010 The block SHALL have port retire, output, 1 bit: one-cycle pulse per completed instruction.
REQ-011 The block SHALL have port carry, output, 1 bit: carry flag register.
REQ-012 The block SHALL have port dbg_sel, input, 2 bits: debug register select.
REQ-013 The block SHALL have port dbg_data, output, DW bits: combinational value of register dbg_sel.

Function
REQ-014 Instruction fields SHALL be: op[15:12], rd[11:10], rs1[9:8], rs2[7:6], imm[7:0]; four general registers r0..r3, none hardwired.
REQ-015 Opcodes SHALL be: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (unsigned, result 1/0), 5 LDI rd<=imm, 6 LD rd<=dmem[rs1], 7 ST dmem[rs1]<=rs2, 8 BEQ (if rd==rs1, PC<=imm else PC+1), 9 JMP PC<=imm, 15 HALT, 10-14 NOP.
REQ-016 ALU results SHALL be modulo 2^DW; ADD sets carry to bit DW of the sum; SUB sets carry to 1 when rs1<rs2 unsigned (borrow); other opcodes leave carry unchanged.
REQ-017 imm SHALL be zero-extended or truncated to DW for LDI, and truncated to IMEM_AW for BEQ/JMP; LD/ST addresses SHALL be rs1 zero-extended or truncated to DMEM_AW.
REQ-018 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALTED.
REQ-019 FETCH: when run=1, the block SHALL latch imem_data into IR and go to DECODE; when run=0, it SHALL hold with PC unchanged. run SHALL be ignored in all other states.
REQ-020 DECODE SHALL latch operands A=reg[rs1] and B=reg[rs2] (BEQ: A=reg[rd], B=reg[rs1]), then go to EXEC.
REQ-021 EXEC SHALL compute the result and route as follows: ALU/LDI to WB; LD to MEM; ST writes dmem; BEQ/JMP/NOP update PC; HALT goes to HALTED.
REQ-022 EXEC SHALL complete ST, BEQ, JMP, and NOP in that state and return to FETCH.
REQ-023 MEM SHALL read dmem into the result register and go to WB; WB SHALL write rd, set PC<=PC+1 and go to FETCH.
REQ-024 Latency from FETCH accept to retire SHALL be: ALU/LDI 4 cycles (retire in WB); LD 5 cycles; ST/BEQ/JMP/NOP 3 cycles (retire in EXEC).
REQ-025 PC+1 SHALL wrap from 2^IMEM_AW-1 to 0.
REQ-026 HALTED SHALL be exited only by reset; while halted, PC, registers and dmem SHALL be frozen, halted=1 and retire=0.
REQ-027 Only one register write SHALL occur per instruction.

Reset
REQ-028 On reset=1 at a clock edge, regardless of state, the block SHALL set state=FETCH, PC=0, r0..r3=0, carry=0, IR=0, retire=0 and halted=0; any in-flight register or memory write that cycle SHALL be suppressed.
REQ-029 dmem contents SHALL NOT be reset.

Structure
REQ-030 Opcode constants and the state encoding SHALL reside in shared package cpu_pkg.
REQ-031 The ALU SHALL be a separate combinational sub-module cpu_alu (DW-parameterised: AND/OR/ADD/SUB/SLT, result plus carry).
REQ-032 The register file and dmem SHALL be inline arrays.

Verification
REQ-033 DW=8: LDI r1,200; LDI r2,100; ADD r3,r1,r2 -> r3=44, carry=1; ADD retire occurs exactly 4 cycles after its fetch.
REQ-034 LDI r0,3; LDI r1,5; SUB r2,r0,r1 -> r2=254, carry=1; SLT r3,r0,r1 -> r3=1.
REQ-035 LDI r1,7; LDI r2,0x5A; ST [r1],r2; LD r3,[r1] -> r3=0x5A; ST retires in 3 cycles and LD in 5.
REQ-036 BEQ equal -> PC=imm; BEQ unequal -> PC+1; JMP 15 followed by an ALU op at 15 -> PC wraps to 0.
REQ-037 run=0 holds FETCH with imem_addr stable; HALT -> halted=1 with all state frozen; reset asserted during EXEC of an ADD -> PC=0, registers 0, no write.
REQ-038 DW=4: LDI r1,0xAB -> dbg_data(sel=1)=0xB; ADD 0xF+0x1 -> 0x0 with carry=1.
